// File: rtl/keyboard_decoder.sv
// keyboard_decoder: PS/2 set-2 scan codes to ASCII via keymap ROM with Shift/Caps/Ctrl tracking
module keyboard_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       scancode_valid,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, BREAK, EXT, EXT_BREAK, LOOKUP, FETCH} state_t;
  state_t state, state_n;
  logic shift_l, shift_r, ctrl, caps_lock;
  logic shift_l_n, shift_r_n, ctrl_n, caps_lock_n;
  logic [9:0] rom_addr_n;
  logic [7:0] ascii_n, ch;
  logic ascii_valid_n, overrun_n;
  // Ctrl folds letters/symbols in 0x40-0x7F down to control codes
  assign ch = (ctrl && rom_data[7:6] == 2'b01) ? {3'b000, rom_data[4:0]} : rom_data;
  // next-state, modifier tracking and output handshake
  always_comb begin
    state_n       = state;
    shift_l_n     = shift_l;
    shift_r_n     = shift_r;
    ctrl_n        = ctrl;
    caps_lock_n   = caps_lock;
    rom_addr_n    = rom_addr;
    ascii_n       = ascii;
    ascii_valid_n = ascii_valid && !ascii_ready;
    overrun_n     = 1'b0;
    case (state)
      IDLE: if (scancode_valid) begin
        case (scancode)
          8'hF0: state_n = BREAK;
          8'hE0: state_n = EXT;
          8'h12: shift_l_n = 1'b1;
          8'h59: shift_r_n = 1'b1;
          8'h14: ctrl_n = 1'b1;
          8'h58: caps_lock_n = ~caps_lock;
          default: begin
            rom_addr_n = {caps_lock, shift_l | shift_r, scancode};
            state_n    = LOOKUP;
          end
        endcase
      end
      BREAK: if (scancode_valid) begin
        shift_l_n = (scancode == 8'h12) ? 1'b0 : shift_l;
        shift_r_n = (scancode == 8'h59) ? 1'b0 : shift_r;
        ctrl_n    = (scancode == 8'h14) ? 1'b0 : ctrl;
        state_n   = IDLE;
      end
      EXT: if (scancode_valid) begin
        ctrl_n  = (scancode == 8'h14) ? 1'b1 : ctrl;
        state_n = (scancode == 8'hF0) ? EXT_BREAK : IDLE;
      end
      EXT_BREAK: if (scancode_valid) begin
        ctrl_n  = (scancode == 8'h14) ? 1'b0 : ctrl;
        state_n = IDLE;
      end
      LOOKUP: state_n = FETCH;
      FETCH: begin
        state_n = IDLE;
        if (rom_data != 8'h00) begin
          if (!ascii_valid || ascii_ready) begin
            ascii_n       = ch;
            ascii_valid_n = 1'b1;
          end else begin
            overrun_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      ctrl        <= 1'b0;
      caps_lock   <= 1'b0;
      rom_addr    <= '0;
      ascii       <= '0;
      ascii_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      shift_l     <= shift_l_n;
      shift_r     <= shift_r_n;
      ctrl        <= ctrl_n;
      caps_lock   <= caps_lock_n;
      rom_addr    <= rom_addr_n;
      ascii       <= ascii_n;
      ascii_valid <= ascii_valid_n;
      overrun     <= overrun_n;
    end
  end
endmodule

// File: tb/tb_keyboard_decoder.sv
// tb_keyboard_decoder: directed checks of decoding, modifiers, handshake, overrun and reset
module tb_keyboard_decoder;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] scancode;
  logic scancode_valid;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] ascii;
  logic ascii_valid;
  logic ascii_ready;
  logic overrun;
  logic [7:0] rom [0:1023];
  int compared = 0;
  int mismatched = 0;
  int accepts = 0;
  int ovr_cnt = 0;
  logic [7:0] last_char = 8'h00;

  keyboard_decoder dut (
    .clk(clk), .reset(reset), .scancode(scancode), .scancode_valid(scancode_valid),
    .rom_addr(rom_addr), .rom_data(rom_data), .ascii(ascii), .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // keymap ROM with one-cycle registered read
  always @(posedge clk) rom_data <= rom[rom_addr];

  // consumer-side record of accepted characters and overrun pulses
  always @(posedge clk) begin
    if (ascii_valid && ascii_ready) begin
      accepts <= accepts + 1;
      last_char <= ascii;
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic key(input logic [7:0] c);
    scancode = c;
    scancode_valid = 1'b1;
    @(posedge clk); #1;
    scancode_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    scancode = 8'h00;
    scancode_valid = 1'b0;
    ascii_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared += 4;
    if (rom_addr !== 10'h000) begin mismatched++; $display("FAIL reset_rom_addr got %h want 000", rom_addr); end
    if (ascii !== 8'h00) begin mismatched++; $display("FAIL reset_ascii got %h want 00", ascii); end
    if (ascii_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", ascii_valid); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun got %b want 0", overrun); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timing;
    scancode = 8'h1C;
    scancode_valid = 1'b1;
    @(posedge clk); #1;
    scancode_valid = 1'b0;
    compared += 2;
    if (rom_addr !== 10'h01C) begin mismatched++; $display("FAIL t1_rom_addr got %h want 01c", rom_addr); end
    if (ascii_valid !== 1'b0) begin mismatched++; $display("FAIL t1_valid got %b want 0", ascii_valid); end
    @(posedge clk); #1;
    compared++;
    if (ascii_valid !== 1'b0) begin mismatched++; $display("FAIL t2_valid got %b want 0", ascii_valid); end
    @(posedge clk); #1;
    compared += 2;
    if (ascii_valid !== 1'b1) begin mismatched++; $display("FAIL t3_valid got %b want 1", ascii_valid); end
    if (ascii !== 8'h61) begin mismatched++; $display("FAIL t3_ascii got %h want 61", ascii); end
    @(posedge clk); #1;
    compared += 2;
    if (ascii_valid !== 1'b0) begin mismatched++; $display("FAIL t4_valid got %b want 0", ascii_valid); end
    if (last_char !== 8'h61) begin mismatched++; $display("FAIL t4_accepted got %h want 61", last_char); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_shift;
    key(8'h12);
    key(8'h1C);
    compared += 2;
    if (rom_addr !== 10'h11C) begin mismatched++; $display("FAIL shift_addr got %h want 11c", rom_addr); end
    if (last_char !== 8'h41) begin mismatched++; $display("FAIL shift_char got %h want 41", last_char); end
    key(8'hF0);
    key(8'h12);
    key(8'h1C);
    compared += 2;
    if (rom_addr !== 10'h01C) begin mismatched++; $display("FAIL unshift_addr got %h want 01c", rom_addr); end
    if (last_char !== 8'h61) begin mismatched++; $display("FAIL unshift_char got %h want 61", last_char); end
    key(8'h59);
    key(8'h1C);
    compared++;
    if (rom_addr !== 10'h11C) begin mismatched++; $display("FAIL rshift_addr got %h want 11c", rom_addr); end
    key(8'hF0);
    key(8'h59);
  endtask

  task automatic test_caps;
    key(8'h58);
    key(8'hF0);
    key(8'h58);
    key(8'h1C);
    compared += 2;
    if (rom_addr !== 10'h21C) begin mismatched++; $display("FAIL caps_addr got %h want 21c", rom_addr); end
    if (last_char !== 8'h41) begin mismatched++; $display("FAIL caps_char got %h want 41", last_char); end
    key(8'h58);
    key(8'h1C);
    compared++;
    if (rom_addr !== 10'h01C) begin mismatched++; $display("FAIL uncaps_addr got %h want 01c", rom_addr); end
  endtask

  task automatic test_ctrl;
    key(8'h14);
    key(8'h21);
    compared++;
    if (last_char !== 8'h03) begin mismatched++; $display("FAIL ctrl_char got %h want 03", last_char); end
    key(8'hE0);
    key(8'hF0);
    key(8'h14);
    key(8'h21);
    compared++;
    if (last_char !== 8'h63) begin mismatched++; $display("FAIL unctrl_char got %h want 63", last_char); end
    key(8'hE0);
    key(8'h14);
    key(8'h32);
    compared++;
    if (last_char !== 8'h02) begin mismatched++; $display("FAIL rctrl_char got %h want 02", last_char); end
    key(8'hE0);
    key(8'hF0);
    key(8'h14);
  endtask

  task automatic test_ignored;
    int n;
    n = accepts;
    key(8'hF0);
    key(8'h1C);
    key(8'hE0);
    key(8'h75);
    compared += 2;
    if (rom_addr !== 10'h032) begin mismatched++; $display("FAIL prefix_addr got %h want 032", rom_addr); end
    if (accepts !== n) begin mismatched++; $display("FAIL prefix_chars got %0d want %0d", accepts, n); end
    key(8'h07);
    compared += 2;
    if (rom_addr !== 10'h007) begin mismatched++; $display("FAIL unmapped_addr got %h want 007", rom_addr); end
    if (accepts !== n) begin mismatched++; $display("FAIL unmapped_chars got %0d want %0d", accepts, n); end
  endtask

  task automatic test_overrun;
    int n;
    ascii_ready = 1'b0;
    n = ovr_cnt;
    key(8'h1C);
    key(8'h32);
    compared += 3;
    if (ascii !== 8'h61) begin mismatched++; $display("FAIL ovr_ascii got %h want 61", ascii); end
    if (ascii_valid !== 1'b1) begin mismatched++; $display("FAIL ovr_valid got %b want 1", ascii_valid); end
    if (ovr_cnt !== n + 1) begin mismatched++; $display("FAIL ovr_pulses got %0d want %0d", ovr_cnt, n + 1); end
    ascii_ready = 1'b1;
    @(posedge clk); #1;
    compared += 2;
    if (ascii_valid !== 1'b0) begin mismatched++; $display("FAIL accept_valid got %b want 0", ascii_valid); end
    if (last_char !== 8'h61) begin mismatched++; $display("FAIL accept_char got %h want 61", last_char); end
  endtask

  task automatic test_back_to_back;
    int n;
    ascii_ready = 1'b0;
    n = ovr_cnt;
    key(8'h1C);
    scancode = 8'h32;
    scancode_valid = 1'b1;
    @(posedge clk); #1;
    scancode_valid = 1'b0;
    @(posedge clk); #1;
    ascii_ready = 1'b1;
    @(posedge clk); #1;
    compared += 4;
    if (ascii_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid got %b want 1", ascii_valid); end
    if (ascii !== 8'h62) begin mismatched++; $display("FAIL b2b_ascii got %h want 62", ascii); end
    if (last_char !== 8'h61) begin mismatched++; $display("FAIL b2b_first got %h want 61", last_char); end
    if (ovr_cnt !== n) begin mismatched++; $display("FAIL b2b_overrun got %0d want %0d", ovr_cnt, n); end
    @(posedge clk); #1;
    compared += 2;
    if (ascii_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_drain got %b want 0", ascii_valid); end
    if (last_char !== 8'h62) begin mismatched++; $display("FAIL b2b_second got %h want 62", last_char); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    ascii_ready = 1'b0;
    key(8'h1C);
    key(8'h12);
    key(8'h58);
    scancode = 8'h32;
    scancode_valid = 1'b1;
    @(posedge clk); #1;
    scancode_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    compared += 4;
    if (rom_addr !== 10'h000) begin mismatched++; $display("FAIL mid_rom_addr got %h want 000", rom_addr); end
    if (ascii !== 8'h00) begin mismatched++; $display("FAIL mid_ascii got %h want 00", ascii); end
    if (ascii_valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid got %b want 0", ascii_valid); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL mid_overrun got %b want 0", overrun); end
    repeat (3) @(posedge clk); #1;
    compared++;
    if (ascii_valid !== 1'b0) begin mismatched++; $display("FAIL mid_lost got %b want 0", ascii_valid); end
    ascii_ready = 1'b1;
    key(8'h1C);
    compared += 2;
    if (rom_addr !== 10'h01C) begin mismatched++; $display("FAIL mid_mods_addr got %h want 01c", rom_addr); end
    if (last_char !== 8'h61) begin mismatched++; $display("FAIL mid_char got %h want 61", last_char); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    rom[10'h01C] = 8'h61;
    rom[10'h11C] = 8'h41;
    rom[10'h21C] = 8'h41;
    rom[10'h31C] = 8'h61;
    rom[10'h021] = 8'h63;
    rom[10'h032] = 8'h62;
    test_reset();
    test_timing();
    test_shift();
    test_caps();
    test_ctrl();
    test_ignored();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/keyboard_decoder.md
# keyboard_decoder

Scan-code decoder between the PS/2 receiver and the 1 KB keymap ROM. It consumes raw set-2 scan-code bytes and tracks the Shift, Caps Lock and Ctrl modifier state. It forms the 10-bit `{caps, shift, code}` keymap address and reads the ROM, which has a one-cycle registered read. It then applies Ctrl folding and presents the resulting ASCII character to the terminal input logic over a valid/ready handshake.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `scancode` input 8: received PS/2 byte.
- `scancode_valid` input 1: one-cycle strobe marking `scancode` valid.
- `rom_addr` output 10: keymap ROM address `{caps_lock, shift, code[7:0]}`; registered.
- `rom_data` input 8: keymap ROM data, valid the cycle after `rom_addr` is held.
- `ascii` output 8: decoded character.
- `ascii_valid` output 1: character pending; held until accepted.
- `ascii_ready` input 1: consumer accepts when `ascii_valid && ascii_ready`.
- `overrun` output 1: one-cycle pulse when a decoded character is dropped because one is still pending.

## Operation
- Reset values:
  - Outputs: `rom_addr`=0, `ascii`=0, `ascii_valid`=0, `overrun`=0.
  - Internal: `shift_l`, `shift_r`, `ctrl`, `caps_lock` all 0; state IDLE.
- States: IDLE, BREAK, EXT, EXT_BREAK, LOOKUP, FETCH.
- IDLE, on `scancode_valid`:
  - 0xF0 → BREAK.
  - 0xE0 → EXT.
  - 0x12 → `shift_l`=1.
  - 0x59 → `shift_r`=1.
  - 0x14 → `ctrl`=1.
  - 0x58 → toggle `caps_lock`.
  - Any other code → latch `rom_addr` = `{caps_lock, shift_l|shift_r, scancode}`, go to LOOKUP.
- BREAK, on `scancode_valid`:
  - 0x12 clears `shift_l`, 0x59 clears `shift_r`, 0x14 clears `ctrl`.
  - All other codes (including 0x58) are ignored.
  - Then → IDLE.
- EXT, on `scancode_valid`:
  - 0xF0 → EXT_BREAK.
  - 0x14 (right Ctrl) → `ctrl`=1, → IDLE.
  - Anything else is discarded, → IDLE. Extended keys produce no character.
- EXT_BREAK, on `scancode_valid`: 0x14 clears `ctrl`; → IDLE.
- LOOKUP: one cycle, unconditional → FETCH. The ROM samples `rom_addr` on this cycle's edge.
- FETCH: `rom_data` is valid; compute the character, → IDLE.
  - `rom_data`==0x00 (unmapped key) → no output.
  - `ctrl`=1 and `rom_data` in 0x40–0x7F → character = `rom_data & 0x1F`; otherwise character = `rom_data`.
  - If `ascii_valid`=0, or it is being accepted this cycle: load `ascii`, set `ascii_valid`.
  - Else drop the character, pulse `overrun`; the pending `ascii` is unchanged.
- Output handshake:
  - `ascii_valid` clears on the cycle after `ascii_valid && ascii_ready`, unless FETCH reloads it on that same edge.
  - `ascii` is stable while `ascii_valid`=1 and not accepted.
- `scancode_valid` during LOOKUP or FETCH: the byte is dropped. Upstream guarantees at least 4 cycles between strobes, which PS/2 rate always satisfies.
- Modifier and caps state persist across characters. Only `reset` clears them.
- Typematic repeat of a held Shift/Ctrl make code re-sets the flag (idempotent). Repeated 0x58 make codes toggle caps each time, matching the ROM's plane semantics.

## Timing
- Strobe at cycle T (IDLE, ordinary code) → `rom_addr` updated at T+1 (LOOKUP) → `rom_data` valid at T+2 (FETCH) → `ascii_valid`=1 at T+3.
- Prefix and modifier bytes are absorbed in 1 cycle with no ROM access; `rom_addr` holds its previous value.
- Consumer acceptance: `ascii_valid` drops one cycle after the accept edge; zero-bubble reload is possible if FETCH coincides with acceptance.
- `reset` asserted in any state: all state clears on that edge. A pending character and any in-flight lookup are lost; no `overrun` pulse.

## Test plan
- After reset, send 0x1C (ROM[0x01C]=0x61), `ascii_ready`=1 → `rom_addr`=0x01C at T+1; `ascii`=0x61 with `ascii_valid` at T+3 for 1 cycle.
- Send 0x12, then 0x1C (ROM[0x11C]=0x41) → `rom_addr`=0x11C, `ascii`=0x41. Then 0xF0 0x12, 0x1C → `rom_addr`=0x01C.
- Send 0x58, 0xF0 0x58, 0x1C (ROM[0x21C]=0x41) → `rom_addr`=0x21C. A second 0x58 returns the plane to 0x01C.
- Send 0x14, then 0x21 (ROM[0x021]=0x63) → `ascii`=0x03. Send 0xE0 0xF0 0x14 → the next 0x21 yields 0x63.
- Send 0xF0 0x1C; send 0xE0 0x75; send a code whose ROM entry is 0x00 → no `ascii_valid`, `rom_addr` is not updated by either prefixed sequence.
- With `ascii_ready`=0, send 0x1C then 0x32 → `ascii` stays 0x61 and `overrun` pulses once. Raise `ascii_ready` → accepted, `ascii_valid` drops the next cycle. Assert `reset` mid-LOOKUP → all outputs return to 0.
